// File: rtl/image_gauss3x3_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : image_gauss3x3_pkg
// Description : Shared types and constants for the 3x3 Gaussian blur stage.
//               It holds the default frame geometry, the FSM state encoding,
//               the kernel normalisation constants and the pixel and window
//               column structures.
// Revision    : 1.0 - initial release
// ============================================================================
package image_gauss3x3_pkg;

   localparam int c_def_width    = 768;
   localparam int c_def_height   = 512;
   localparam int c_pix_w        = 24;
   localparam int c_kernel_shift = 4;   // kernel weights sum to 16
   localparam int c_kernel_round = 8;   // half of 16, for round-to-nearest

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } gauss_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   // One window column. top is the oldest row and bot is the newest row.
   typedef struct packed {
      rgb_t top;
      rgb_t mid;
      rgb_t bot;
   } column_t;

endpackage
`default_nettype wire

// File: rtl/image_gauss3x3_line_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gauss_line_buffer
// Description : Row memory that is DEPTH entries deep. The read is
//               combinational and the write is synchronous, both at the same
//               address, so a read in the write cycle returns the old content
//               (read-before-write).
// Ports       : clk      - clock
//               i_we     - write enable (one advance)
//               i_addr   - column address for read and write
//               i_wdata  - data written at i_addr
//               o_rdata  - current content at i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module gauss_line_buffer
   import image_gauss3x3_pkg::*;
#(
   parameter int DEPTH  = c_def_width,
   parameter int DATA_W = c_pix_w,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/image_gauss3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : image_gauss3x3
// Description : Streaming 3x3 Gaussian blur ([1 2 1;2 4 2;1 2 1] / 16, with
//               rounding) on raster-order RGB. The stage emits one output per
//               input pixel. Border pixels pass through unchanged. After the
//               last input pixel the stage drains the final row by itself.
// Ports       : HCLK, HRESET (async, active high)
//               in_hsync, in_R/G/B     - input pixel strobe and data
//               out_hsync, out_R/G/B   - output pixel strobe and data
//               frame_done             - pulse one cycle after last output
//               err                    - sticky: input seen in FLUSH/DONE
// Revision    : 1.0 - initial release
// ============================================================================
module image_gauss3x3
   import image_gauss3x3_pkg::*;
#(
   parameter int WIDTH  = c_def_width,
   parameter int HEIGHT = c_def_height
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       in_hsync,
   input  logic [7:0] in_R,
   input  logic [7:0] in_G,
   input  logic [7:0] in_B,
   output logic       out_hsync,
   output logic [7:0] out_R,
   output logic [7:0] out_G,
   output logic [7:0] out_B,
   output logic       frame_done,
   output logic       err
);

   localparam int c_col_w = $clog2(WIDTH);
   localparam int c_row_w = $clog2(HEIGHT);
   localparam logic [c_col_w-1:0] c_last_col = c_col_w'(WIDTH - 1);
   localparam logic [c_row_w-1:0] c_last_row = c_row_w'(HEIGHT - 1);
   localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);

   function automatic logic [7:0] get_chan(input rgb_t p, input logic [1:0] ch);
      case (ch)
         2'd0:    get_chan = p.r;
         2'd1:    get_chan = p.g;
         default: get_chan = p.b;
      endcase
   endfunction

   // The window is given as three columns l, m, r. The 12-bit sum cannot
   // overflow: 16*255 + 8 = 4088.
   function automatic logic [7:0] gauss_kernel(input column_t l, input column_t m,
                                               input column_t r, input logic [1:0] ch);
      logic [11:0] s;
      s = 12'(get_chan(l.top, ch)) + 12'(get_chan(r.top, ch))
        + 12'(get_chan(l.bot, ch)) + 12'(get_chan(r.bot, ch))
        + (12'(get_chan(m.top, ch)) << 1) + (12'(get_chan(m.bot, ch)) << 1)
        + (12'(get_chan(l.mid, ch)) << 1) + (12'(get_chan(r.mid, ch)) << 1)
        + (12'(get_chan(m.mid, ch)) << 2) + 12'(c_kernel_round);
      gauss_kernel = 8'(s >> c_kernel_shift);
   endfunction

   gauss_state_t        r_state;
   logic [c_col_w-1:0]  r_in_col;
   logic [c_row_w-1:0]  r_in_row;
   logic [c_col_w-1:0]  r_out_col;
   logic [c_row_w-1:0]  r_out_row;
   column_t             r_col0;      // older of the two stored window columns
   column_t             r_col1;      // newer one; its mid is the centre pixel

   logic    w_accept;
   logic    w_adv;
   logic    w_emit;
   logic    w_border;
   rgb_t    w_pix_in;
   rgb_t    w_lb0_rd;
   rgb_t    w_lb1_rd;
   column_t w_col_new;
   rgb_t    w_blur;
   rgb_t    w_out;

   assign w_accept = in_hsync && (r_state == ST_IDLE || r_state == ST_FILL || r_state == ST_RUN);
   // During FLUSH the window advances every cycle and zeros are shifted in.
   assign w_adv    = w_accept || (r_state == ST_FLUSH);
   assign w_emit   = (w_accept && r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign w_pix_in = (r_state == ST_FLUSH) ? '0 : {in_R, in_G, in_B};

   // Chained line buffers: buffer 1 receives what buffer 0 held one row earlier.
   gauss_line_buffer #(
      .DEPTH  (WIDTH),
      .DATA_W (c_pix_w),
      .ADDR_W (c_col_w)
   ) u_lb0 (
      .clk     (HCLK),
      .i_we    (w_adv),
      .i_addr  (r_in_col),
      .i_wdata (w_pix_in),
      .o_rdata (w_lb0_rd)
   );

   gauss_line_buffer #(
      .DEPTH  (WIDTH),
      .DATA_W (c_pix_w),
      .ADDR_W (c_col_w)
   ) u_lb1 (
      .clk     (HCLK),
      .i_we    (w_adv),
      .i_addr  (r_in_col),
      .i_wdata (w_lb0_rd),
      .o_rdata (w_lb1_rd)
   );

   assign w_col_new = {w_lb1_rd, w_lb0_rd, w_pix_in};

   assign w_blur.r = gauss_kernel(r_col0, r_col1, w_col_new, 2'd0);
   assign w_blur.g = gauss_kernel(r_col0, r_col1, w_col_new, 2'd1);
   assign w_blur.b = gauss_kernel(r_col0, r_col1, w_col_new, 2'd2);

   // Border centres read line-buffer content from the previous frame, or
   // wrap across a row end, so they bypass the kernel.
   assign w_border = (r_out_row == '0) || (r_out_row == c_last_row) ||
                     (r_out_col == '0) || (r_out_col == c_last_col);
   assign w_out    = w_border ? r_col1.mid : w_blur;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_state    <= ST_IDLE;
         r_in_col   <= '0;
         r_in_row   <= '0;
         r_out_col  <= '0;
         r_out_row  <= '0;
         r_col0     <= '0;
         r_col1     <= '0;
         out_hsync  <= 1'b0;
         out_R      <= '0;
         out_G      <= '0;
         out_B      <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         out_hsync  <= 1'b0;
         frame_done <= 1'b0;

         if (in_hsync && (r_state == ST_FLUSH || r_state == ST_DONE)) begin
            err <= 1'b1;
         end

         if (w_adv) begin
            r_col0 <= r_col1;
            r_col1 <= w_col_new;
            if (r_in_col == c_last_col) begin
               r_in_col <= '0;
               r_in_row <= (r_in_row == c_last_row) ? '0 : r_in_row + 1'b1;
            end else begin
               r_in_col <= r_in_col + 1'b1;
            end
         end

         if (w_emit) begin
            out_hsync <= 1'b1;
            out_R     <= w_out.r;
            out_G     <= w_out.g;
            out_B     <= w_out.b;
            if (r_out_col == c_last_col) begin
               r_out_col <= '0;
               r_out_row <= (r_out_row == c_last_row) ? '0 : r_out_row + 1'b1;
            end else begin
               r_out_col <= r_out_col + 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_accept) r_state <= ST_FILL;
            end
            ST_FILL: begin
               // Input index WIDTH (row 1, col 0) is the last pixel without an output.
               if (w_accept && r_in_row == c_row_one && r_in_col == '0) r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_accept && r_in_row == c_last_row && r_in_col == c_last_col) r_state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (r_out_row == c_last_row && r_out_col == c_last_col) r_state <= ST_DONE;
            end
            ST_DONE: begin
               frame_done <= 1'b1;
               r_in_col   <= '0;
               r_in_row   <= '0;
               r_out_col  <= '0;
               r_out_row  <= '0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_image_gauss3x3.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_image_gauss3x3
// Description : Scoreboard bench for image_gauss3x3. Two instances are used:
//               A is 4x3 (constant, gapped, overrun and mid-frame reset) and
//               B is 5x5 (impulse and ramp). Expected pixels are queued when
//               each stimulus pixel is issued, and a negedge monitor pops and
//               compares them on every out_hsync.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_gauss3x3;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   logic       a_hs, a_ohs, a_fd, a_err;
   logic [7:0] a_R, a_G, a_B, a_oR, a_oG, a_oB;
   logic       b_hs, b_ohs, b_fd, b_err;
   logic [7:0] b_R, b_G, b_B, b_oR, b_oG, b_oB;

   image_gauss3x3 #(.WIDTH(4), .HEIGHT(3)) dut_a (
      .HCLK(HCLK), .HRESET(HRESET), .in_hsync(a_hs), .in_R(a_R), .in_G(a_G), .in_B(a_B),
      .out_hsync(a_ohs), .out_R(a_oR), .out_G(a_oG), .out_B(a_oB),
      .frame_done(a_fd), .err(a_err)
   );

   image_gauss3x3 #(.WIDTH(5), .HEIGHT(5)) dut_b (
      .HCLK(HCLK), .HRESET(HRESET), .in_hsync(b_hs), .in_R(b_R), .in_G(b_G), .in_B(b_B),
      .out_hsync(b_ohs), .out_R(b_oR), .out_G(b_oG), .out_B(b_oB),
      .frame_done(b_fd), .err(b_err)
   );

   int total = 0;
   int bad   = 0;
   logic [23:0] q_a[$];
   logic [23:0] q_b[$];
   int   cnt_a = 0, cnt_b = 0, done_a = 0, done_b = 0;
   logic prev_a = 1'b0, prev_b = 1'b0;
   logic [23:0] img_in  [25];
   logic [23:0] img_exp [25];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every output against the scoreboard and checks the
   // frame_done placement and the per-frame output count.
   always @(negedge HCLK) begin
      if (HRESET) begin
         cnt_a = 0; cnt_b = 0; prev_a = 1'b0; prev_b = 1'b0;
      end else begin
         if (a_ohs) begin
            check("a_expected_queued", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) check("a_out_pixel", int'({a_oR, a_oG, a_oB}), int'(q_a.pop_front()));
            cnt_a++;
         end
         if (a_fd) begin
            check("a_outputs_per_frame", cnt_a, 12);
            check("a_done_after_last_out", int'(prev_a), 1);
            cnt_a = 0;
            done_a++;
         end
         prev_a = a_ohs;
         if (b_ohs) begin
            check("b_expected_queued", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) check("b_out_pixel", int'({b_oR, b_oG, b_oB}), int'(q_b.pop_front()));
            cnt_b++;
         end
         if (b_fd) begin
            check("b_outputs_per_frame", cnt_b, 25);
            check("b_done_after_last_out", int'(prev_b), 1);
            cnt_b = 0;
            done_b++;
         end
         prev_b = b_ohs;
      end
   end

   task automatic drive(input int sel, input logic hs, input logic [23:0] px);
      if (sel == 0) begin a_hs = hs; {a_R, a_G, a_B} = px; end
      else          begin b_hs = hs; {b_R, b_G, b_B} = px; end
   endtask

   task automatic push(input int sel, input logic [23:0] e);
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
   endtask

   // Sends npix pixels from img_in. Output k belongs to input k+w+1. For a
   // full frame the w+1 drained outputs are queued right after the last pixel.
   task automatic send_frame(input int sel, input int w, input int h, input int gap, input int npix);
      for (int k = 0; k < npix; k++) begin
         drive(sel, 1'b1, img_in[k]);
         if (k >= w + 1) push(sel, img_exp[k - w - 1]);
         @(posedge HCLK); #1;
         drive(sel, 1'b0, 24'h0);
         if (k == npix - 1 && npix == w * h)
            for (int j = w * h - w - 1; j < w * h; j++) push(sel, img_exp[j]);
         if (k != npix - 1) repeat (gap) begin @(posedge HCLK); #1; end
      end
   endtask

   task automatic wait_frame(input int sel, input int start, input string name);
      int n;
      n = 0;
      while (((sel == 0) ? done_a : done_b) == start && n < 100) begin
         @(posedge HCLK); #1;
         n++;
      end
      check({name, "_done_seen"}, int'(((sel == 0) ? done_a : done_b) != start), 1);
      repeat (6) begin @(posedge HCLK); #1; end
      check({name, "_done_once"}, (sel == 0) ? done_a : done_b, start + 1);
      check({name, "_queue_empty"}, (sel == 0) ? q_a.size() : q_b.size(), 0);
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < 25; i++) begin img_in[i] = {v, v, v}; img_exp[i] = {v, v, v}; end
   endtask

   initial begin
      int s;
      HRESET = 1'b1;
      drive(0, 1'b0, 24'h0);
      drive(1, 1'b0, 24'h0);
      repeat (3) @(posedge HCLK);
      #1;
      check("rst_a_hsync", int'(a_ohs), 0);
      check("rst_a_data", int'({a_oR, a_oG, a_oB}), 0);
      check("rst_a_done_err", int'({a_fd, a_err}), 0);
      check("rst_b_hsync", int'(b_ohs), 0);
      check("rst_b_data", int'({b_oR, b_oG, b_oB}), 0);
      check("rst_b_done_err", int'({b_fd, b_err}), 0);
      HRESET = 1'b0;
      @(posedge HCLK); #1;

      // Constant 4x3 frame of 100
      fill_const(8'd100);
      s = done_a;
      send_frame(0, 4, 3, 0, 12);
      wait_frame(0, s, "const100");

      // Same frame with in_hsync high every third cycle
      s = done_a;
      send_frame(0, 4, 3, 2, 12);
      wait_frame(0, s, "gapped");
      check("gapped_err", int'(a_err), 0);

      // Overrun: in_hsync held high for the whole drain
      fill_const(8'd200);
      s = done_a;
      send_frame(0, 4, 3, 0, 12);
      drive(0, 1'b1, 24'hFFFFFF);
      repeat (5) begin @(posedge HCLK); #1; end
      drive(0, 1'b0, 24'h0);
      wait_frame(0, s, "overrun");
      check("overrun_err_set", int'(a_err), 1);
      repeat (5) begin @(posedge HCLK); #1; end
      check("overrun_err_sticky", int'(a_err), 1);

      // Mid-frame reset after 7 pixels: only centres (0,0),(0,1) were emitted
      fill_const(8'd100);
      send_frame(0, 4, 3, 0, 7);
      @(negedge HCLK); #2;
      HRESET = 1'b1;
      #1;
      check("midrst_hsync", int'(a_ohs), 0);
      check("midrst_data", int'({a_oR, a_oG, a_oB}), 0);
      check("midrst_err_cleared", int'(a_err), 0);
      check("midrst_queue_empty", q_a.size(), 0);
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      @(posedge HCLK); #1;
      fill_const(8'd150);
      s = done_a;
      send_frame(0, 4, 3, 0, 12);
      wait_frame(0, s, "after_rst150");
      check("after_rst150_err", int'(a_err), 0);

      // 5x5 impulse, R(2,2)=160
      for (int i = 0; i < 25; i++) begin img_in[i] = 24'h0; img_exp[i] = 24'h0; end
      img_in[12]  = 24'hA00000;
      img_exp[6]  = 24'h0A0000; img_exp[7]  = 24'h140000; img_exp[8]  = 24'h0A0000;
      img_exp[11] = 24'h140000; img_exp[12] = 24'h280000; img_exp[13] = 24'h140000;
      img_exp[16] = 24'h0A0000; img_exp[17] = 24'h140000; img_exp[18] = 24'h0A0000;
      s = done_b;
      send_frame(1, 5, 5, 0, 25);
      wait_frame(1, s, "impulse");

      // 5x5 ramp 10*r+c: borders pass through, and the linear interior is unchanged
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            img_in[r * 5 + c]  = {3{8'(10 * r + c)}};
            img_exp[r * 5 + c] = {3{8'(10 * r + c)}};
         end
      s = done_b;
      send_frame(1, 5, 5, 1, 25);
      wait_frame(1, s, "ramp");
      check("b_err", int'(b_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
